// File: rtl/shift_pkg.sv
// Shared types for the universal shift register and its tick generator.
package shift_pkg;

   // Operation select; encoding 7 is unused and decodes as HOLD.
   typedef enum logic [2:0] {
      MODE_HOLD = 3'd0,
      MODE_SHL  = 3'd1,
      MODE_SHR  = 3'd2,
      MODE_ROL  = 3'd3,
      MODE_ROR  = 3'd4,
      MODE_LOAD = 3'd5,
      MODE_CLR  = 3'd6
   } mode_e;

   // Counter width for a divider of div cycles; never narrower than one bit.
   function automatic int cnt_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle between a driver (master) and the shift register (slave).
interface univ_shift_reg_if #(
   parameter int WIDTH = 8
);
   import shift_pkg::*;

   logic             en;
   mode_e            mode;
   logic             ser_in;
   logic [WIDTH-1:0] par_in;
   logic [WIDTH-1:0] data_out;
   logic             ser_out;
   logic             tick;

   modport master (
      output en, mode, ser_in, par_in,
      input  data_out, ser_out, tick
   );

   modport slave (
      input  en, mode, ser_in, par_in,
      output data_out, ser_out, tick
   );
endinterface

// File: rtl/tick_gen.sv
// Free-running divider producing a registered one-cycle strobe every DIV clocks.
module tick_gen
   import shift_pkg::*;
#(
   parameter int DIV = 50_000_000
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);
   localparam int CNT_W = cnt_width(DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             tick_reg;

   // Next count wraps at DIV-1; with DIV=1 this pins the counter at zero.
   always_comb begin
      cnt_next = (cnt_reg == CNT_MAX) ? '0 : cnt_reg + CNT_W'(1);
   end

   // Strobe is decoded from the next count so it is high exactly while cnt_reg == DIV-1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_reg  <= '0;
         tick_reg <= 1'b0;
      end else begin
         cnt_reg  <= cnt_next;
         tick_reg <= (cnt_next == CNT_MAX);
      end
   end

   assign tick = tick_reg;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift, rotate, load, clear, gated by a clock-enable tick.
module univ_shift_reg
   import shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIV   = 50_000_000
) (
   input  logic               clk,
   input  logic               reset_n,
   univ_shift_reg_if.slave    bus
);
   logic             tick_w;
   logic [WIDTH-1:0] data_reg;
   logic             ser_reg;

   tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick_w)
   );

   // Register update; only a tick cycle with en high commits an operation.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_reg <= '0;
         ser_reg  <= 1'b0;
      end else if (tick_w && bus.en) begin
         unique case (bus.mode)
            MODE_SHL: begin
               data_reg <= {data_reg[WIDTH-2:0], bus.ser_in};
               ser_reg  <= data_reg[WIDTH-1];
            end
            MODE_SHR: begin
               data_reg <= {bus.ser_in, data_reg[WIDTH-1:1]};
               ser_reg  <= data_reg[0];
            end
            MODE_ROL: begin
               data_reg <= {data_reg[WIDTH-2:0], data_reg[WIDTH-1]};
               ser_reg  <= data_reg[WIDTH-1];
            end
            MODE_ROR: begin
               data_reg <= {data_reg[0], data_reg[WIDTH-1:1]};
               ser_reg  <= data_reg[0];
            end
            MODE_LOAD: begin
               data_reg <= bus.par_in;
            end
            MODE_CLR: begin
               data_reg <= '0;
               ser_reg  <= 1'b0;
            end
            default: begin
               // HOLD and the reserved encoding leave the register untouched.
            end
         endcase
      end
   end

   assign bus.data_out = data_reg;
   assign bus.ser_out  = ser_reg;
   assign bus.tick     = tick_w;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: WIDTH=8/DIV=4 main instance, WIDTH=2/DIV=1 corner instance.
module tb_univ_shift_reg;
   import shift_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic reset2_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   univ_shift_reg_if #(.WIDTH(8)) bus ();
   univ_shift_reg_if #(.WIDTH(2)) bus2 ();

   univ_shift_reg #(.WIDTH(8), .DIV(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   univ_shift_reg #(.WIDTH(2), .DIV(1)) dut2 (
      .clk     (clk),
      .reset_n (reset2_n),
      .bus     (bus2.slave)
   );

   // Advance to the next negedge where tick is high; a missing tick is a failure.
   task automatic wait_tick(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.tick) begin
            seen = 1'b1;
            break;
         end
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s: tick not seen within 20 cycles", name);
      end
   endtask

   // Present an operation during a tick cycle and step to the following negedge.
   task automatic apply(input mode_e m, input logic si, input logic [7:0] pi, input string name);
      wait_tick(name);
      bus.en     = 1'b1;
      bus.mode   = m;
      bus.ser_in = si;
      bus.par_in = pi;
      @(negedge clk);
      bus.en = 1'b0;
   endtask

   task automatic test_reset();
      logic exp_tick;
      reset_n    = 1'b0;
      bus.en     = 1'b1;
      bus.mode   = MODE_LOAD;
      bus.par_in = 8'hFF;
      bus.ser_in = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++;
      if (bus.data_out !== 8'h00) begin
         n_fail++; $display("FAIL reset_data: got %h want 00", bus.data_out);
      end
      n_tests++;
      if (bus.ser_out !== 1'b0) begin
         n_fail++; $display("FAIL reset_ser: got %b want 0", bus.ser_out);
      end
      n_tests++;
      if (bus.tick !== 1'b0) begin
         n_fail++; $display("FAIL reset_tick: got %b want 0", bus.tick);
      end
      reset_n = 1'b1;
      bus.en  = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         exp_tick = (k % 4 == 3);
         n_tests++;
         if (bus.tick !== exp_tick) begin
            n_fail++; $display("FAIL reset_tick_cycle%0d: got %b want %b", k + 1, bus.tick, exp_tick);
         end
      end
      $display("[TB] reset done: data=%h ser=%b", bus.data_out, bus.ser_out);
   endtask

   task automatic test_shl();
      logic [7:0] exp_d [3] = '{8'h4B, 8'h96, 8'h2D};
      logic       exp_s [3] = '{1'b1, 1'b0, 1'b1};
      logic       si    [3] = '{1'b1, 1'b0, 1'b1};
      apply(MODE_LOAD, 1'b0, 8'hA5, "shl_load");
      n_tests++;
      if (bus.data_out !== 8'hA5) begin
         n_fail++; $display("FAIL shl_load: got %h want A5", bus.data_out);
      end
      for (int i = 0; i < 3; i++) begin
         apply(MODE_SHL, si[i], 8'h00, "shl");
         n_tests++;
         if (bus.data_out !== exp_d[i] || bus.ser_out !== exp_s[i]) begin
            n_fail++;
            $display("FAIL shl_%0d: got %h/%b want %h/%b", i, bus.data_out, bus.ser_out, exp_d[i], exp_s[i]);
         end
         $display("[TB] SHL ser_in=%b -> data=%h ser=%b", si[i], bus.data_out, bus.ser_out);
      end
   endtask

   task automatic test_rotate();
      apply(MODE_LOAD, 1'b0, 8'h81, "rot_load");
      apply(MODE_ROR, 1'b0, 8'h00, "ror");
      n_tests++;
      if (bus.data_out !== 8'hC0 || bus.ser_out !== 1'b1) begin
         n_fail++; $display("FAIL ror: got %h/%b want C0/1", bus.data_out, bus.ser_out);
      end
      apply(MODE_LOAD, 1'b0, 8'h81, "rot_reload");
      apply(MODE_ROL, 1'b0, 8'h00, "rol1");
      n_tests++;
      if (bus.data_out !== 8'h03 || bus.ser_out !== 1'b1) begin
         n_fail++; $display("FAIL rol1: got %h/%b want 03/1", bus.data_out, bus.ser_out);
      end
      apply(MODE_ROL, 1'b0, 8'h00, "rol2");
      n_tests++;
      if (bus.data_out !== 8'h06 || bus.ser_out !== 1'b0) begin
         n_fail++; $display("FAIL rol2: got %h/%b want 06/0", bus.data_out, bus.ser_out);
      end
      for (int i = 0; i < 8; i++) apply(MODE_ROL, 1'b0, 8'h00, "rol8");
      n_tests++;
      if (bus.data_out !== 8'h06) begin
         n_fail++; $display("FAIL rol8: got %h want 06", bus.data_out);
      end
      $display("[TB] rotate done: data=%h", bus.data_out);
   endtask

   task automatic test_enable_mode();
      bus.en     = 1'b0;
      bus.mode   = MODE_SHR;
      bus.ser_in = 1'b1;
      for (int i = 0; i < 3; i++) wait_tick("en0");
      @(negedge clk);
      n_tests++;
      if (bus.data_out !== 8'h06) begin
         n_fail++; $display("FAIL en0_hold: got %h want 06", bus.data_out);
      end
      // SHL present only on non-tick cycles, HOLD on the tick cycle.
      bus.en   = 1'b1;
      bus.mode = MODE_SHL;
      @(negedge clk);
      @(negedge clk);
      wait_tick("offtick");
      bus.mode = MODE_HOLD;
      @(negedge clk);
      bus.mode = MODE_SHL;
      n_tests++;
      if (bus.data_out !== 8'h06) begin
         n_fail++; $display("FAIL offtick_mode: got %h want 06", bus.data_out);
      end
      bus.en = 1'b0;
      apply(MODE_ROR, 1'b0, 8'h00, "ror_after");
      n_tests++;
      if (bus.data_out !== 8'h03 || bus.ser_out !== 1'b0) begin
         n_fail++; $display("FAIL ror_after: got %h/%b want 03/0", bus.data_out, bus.ser_out);
      end
      $display("[TB] enable/mode done: data=%h", bus.data_out);
   endtask

   task automatic test_reset_mid();
      int gap = 0;
      apply(MODE_LOAD, 1'b0, 8'h5A, "mid_load");
      @(negedge clk);
      @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      n_tests++;
      if (bus.data_out !== 8'h00 || bus.ser_out !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset: got %h/%b want 00/0", bus.data_out, bus.ser_out);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (bus.tick) begin
            gap = i;
            break;
         end
      end
      n_tests++;
      if (gap != 3) begin
         n_fail++; $display("FAIL mid_tick_gap: first tick at cycle %0d want 4", gap + 1);
      end
      apply(MODE_LOAD, 1'b0, 8'hC3, "mid_load2");
      apply(MODE_SHL, 1'b0, 8'h00, "mid_shl");
      n_tests++;
      if (bus.data_out !== 8'h86 || bus.ser_out !== 1'b1) begin
         n_fail++; $display("FAIL mid_shl: got %h/%b want 86/1", bus.data_out, bus.ser_out);
      end
      apply(mode_e'(3'd7), 1'b1, 8'hFF, "reserved");
      n_tests++;
      if (bus.data_out !== 8'h86 || bus.ser_out !== 1'b1) begin
         n_fail++; $display("FAIL reserved: got %h/%b want 86/1", bus.data_out, bus.ser_out);
      end
      apply(MODE_CLR, 1'b1, 8'hFF, "clr");
      n_tests++;
      if (bus.data_out !== 8'h00 || bus.ser_out !== 1'b0) begin
         n_fail++; $display("FAIL clr: got %h/%b want 00/0", bus.data_out, bus.ser_out);
      end
      $display("[TB] reset-mid/reserved/clr done: data=%h ser=%b", bus.data_out, bus.ser_out);
   endtask

   task automatic test_div1();
      logic [1:0] exp_d [2] = '{2'b10, 2'b11};
      reset2_n    = 1'b0;
      bus2.en     = 1'b0;
      bus2.mode   = MODE_SHR;
      bus2.ser_in = 1'b1;
      bus2.par_in = 2'b00;
      @(negedge clk);
      n_tests++;
      if (bus2.tick !== 1'b0 || bus2.data_out !== 2'b00) begin
         n_fail++; $display("FAIL div1_reset: got tick=%b data=%b want 0/00", bus2.tick, bus2.data_out);
      end
      reset2_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus2.tick !== 1'b1) begin
         n_fail++; $display("FAIL div1_tick: got %b want 1", bus2.tick);
      end
      bus2.en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_tests++;
         if (bus2.data_out !== exp_d[i] || bus2.ser_out !== 1'b0 || bus2.tick !== 1'b1) begin
            n_fail++;
            $display("FAIL div1_shr%0d: got %b/%b tick=%b want %b/0 tick=1",
                     i, bus2.data_out, bus2.ser_out, bus2.tick, exp_d[i]);
         end
         $display("[TB] DIV1 SHR -> data=%b ser=%b", bus2.data_out, bus2.ser_out);
      end
      bus2.en = 1'b0;
   endtask

   initial begin
      bus.en = 1'b0; bus.mode = MODE_HOLD; bus.ser_in = 1'b0; bus.par_in = 8'h00;
      bus2.en = 1'b0; bus2.mode = MODE_HOLD; bus2.ser_in = 1'b0; bus2.par_in = 2'b00;
      test_reset();
      test_shl();
      test_rotate();
      test_enable_mode();
      test_reset_mid();
      test_div1();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register with an integrated clock-enable tick generator; the successor to the fixed 4-bit, left-only, derived-clock shift register. Supports hold, left/right shift, left/right rotate, parallel load and synchronous clear on a WIDTH-bit register. All logic runs on the single system clock, qualified by a one-cycle tick, so no derived clocks exist. Sits between board switches/buttons (or upstream RTL) and LED/parallel consumers in lab top-levels.

## Interface
Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- DIV, 50_000_000, clock cycles per tick; legal range 1..2^26; DIV=1 gives a tick every cycle.

Ports:
- clk  input  1  system clock (50 MHz on board).
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  operation enable; sampled only on tick cycles.
- mode  input  3  operation select, shift_pkg::mode_e encoding.
- ser_in  input  1  serial input; enters LSB on SHL, MSB on SHR.
- par_in  input  WIDTH  parallel load data.
- data_out  output  WIDTH  register contents.
- ser_out  output  1  bit ejected by the most recent SHL/SHR/ROL/ROR.
- tick  output  1  one-cycle tick strobe, exported for cascading and bench sync.

## Operation
- Mode encoding: HOLD=0, SHL=1, SHR=2, ROL=3, ROR=4, LOAD=5, CLR=6; 7 reserved, behaves as HOLD.
- Tick generator: counter cnt runs 0..DIV-1, wraps to 0; tick=1 on exactly the cycle where cnt==DIV-1. DIV=1: counter held at 0, tick=1 every cycle after reset.
- Operation commits on a rising clk edge where tick==1 and en==1; otherwise data_out and ser_out hold.
- SHL: data_out <= {data_out[WIDTH-2:0], ser_in}; ser_out <= old data_out[WIDTH-1].
- SHR: data_out <= {ser_in, data_out[WIDTH-1:1]}; ser_out <= old data_out[0].
- ROL: data_out <= {data_out[WIDTH-2:0], data_out[WIDTH-1]}; ser_out <= old data_out[WIDTH-1].
- ROR: data_out <= {data_out[0], data_out[WIDTH-1:1]}; ser_out <= old data_out[0].
- LOAD: data_out <= par_in; ser_out unchanged.
- CLR: data_out <= 0; ser_out <= 0.
- HOLD/reserved: no change.
- en, mode, ser_in, par_in are synchronous to clk; no internal synchronisers (top-level owns debouncing/sync of board inputs).
- Tick counter is free-running and independent of en/mode.

## Timing
- Reset (async assert, sync-to-clk deassert expected from top): cnt=0, tick=0, data_out=0, ser_out=0.
- First tick: asserted in cycle DIV after reset release (edge count from first active edge: cnt reaches DIV-1 after DIV-1 edges; tick is combinational decode of cnt registered as a flop, so tick is high during the cycle following cnt==DIV-2 → cnt==DIV-1 transition). Tick is a registered output.
- Latency: inputs sampled at the edge ending the tick cycle; data_out/ser_out valid one cycle after the tick cycle, i.e. one clk after sampling.
- Tick period exactly DIV cycles, high for 1 cycle; never two consecutive highs unless DIV=1.
- Reset mid-operation: all state cleared immediately regardless of tick phase; tick phase restarts from 0.
- mode changes between ticks have no effect; only the value present on the tick cycle matters.

## Structure
- Package shift_pkg: mode_e enum (3-bit) with the encodings above; localparam CNT_W = $clog2(DIV) (min 1) computed in the module from DIV.
- Sub-module tick_gen (params DIV; ports clk, reset_n, tick): counter + registered strobe; reused by other lab blocks (counters, LED sequencers).
- univ_shift_reg: instantiates tick_gen, one always_ff for data_out/ser_out with unique case on mode.

## Test plan
(WIDTH=8, DIV=4 unless stated)
- Reset: hold reset_n=0 with par_in=8'hFF, mode=LOAD, en=1 → data_out=8'h00, ser_out=0, tick=0; after release tick pulses every 4th cycle, first at cycle 4.
- LOAD 8'hA5 then SHL ×3 with ser_in=1,0,1 → data_out 8'h4B, 8'h96, 8'h2D; ser_out 1, 0, 1.
- LOAD 8'h81, ROR ×1 → 8'hC0, ser_out=1; ROL ×2 → 8'h03 then 8'h06, ser_out 1 then 0; 8 rotates return the original value.
- en=0 across 3 ticks with mode=SHR → data_out unchanged; mode toggled off-tick then restored before tick → only tick-cycle mode applied.
- Reset asserted mid-period (cnt=2) with data_out=8'h5A → immediate 0; next tick exactly 4 cycles after release; mode=7 on a tick → no change; CLR → 8'h00, ser_out=0.
- DIV=1, WIDTH=2: tick constant 1 after reset; SHR with ser_in=1 for 2 cycles from 2'b00 → 2'b10, 2'b11, ser_out 0, 0.
